// File: rtl/tacho_pkg.sv
// Shared definitions for the fan tachometer: register offsets, CTRL bit map,
// FSM encodings and the saturating counter helper.
package tacho_pkg;

  localparam logic [1:0] TACHO_CTRL   = 2'd0;
  localparam logic [1:0] TACHO_DATA   = 2'd1;
  localparam logic [1:0] TACHO_THRESH = 2'd2;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_STALL = 6;
  localparam int CTRL_VALID = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } tacho_state_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/tacho_if.sv
// CSR bus bundle between the I2C-slave register block and the tachometer.
interface tacho_if;
  logic [4:0] csr_a;
  logic [7:0] csr_di;
  logic       csr_we;
  logic [7:0] csr_do;

  modport master (output csr_a, output csr_di, output csr_we, input  csr_do);
  modport slave  (input  csr_a, input  csr_di, input  csr_we, output csr_do);
endinterface

// File: rtl/tacho_filter.sv
// Tach input conditioning: 2-FF synchronizer, then a FILT_LEN-sample
// majority-free run filter clocked by pulse_ce; emits level and a 1-clk rise.
module tacho_filter #(
  parameter int FILT_LEN = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_ce,
  input  logic tach_in,
  output logic level,
  output logic rise
);

  logic       s1, s2;
  logic [1:0] run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      run   <= 2'd0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= tach_in;
      s2   <= s1;
      rise <= 1'b0;
      if (pulse_ce) begin
        // Count consecutive samples disagreeing with the current level.
        if (s2 != level) begin
          if (run == 2'(FILT_LEN - 1)) begin
            level <= s2;
            run   <= 2'd0;
            rise  <= s2;
          end else begin
            run <= run + 2'd1;
          end
        end else begin
          run <= 2'd0;
        end
      end
    end
  end

endmodule

// File: rtl/tacho.sv
// Fan tachometer: counts filtered tach rising edges per gate_ce interval and
// publishes the count on the CSR bus. Optional stall IRQ under `TACHO_IRQ_EN.
module tacho
  import tacho_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h1c,
  parameter int         FILT_LEN  = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    pulse_ce,
  input  logic    gate_ce,
  input  logic    tach_in,
  tacho_if.slave  bus,
  output logic    irq
);

  tacho_state_e state, state_nxt;
  logic         en, en_nxt, valid, rise, level;
  logic [7:0]   cnt, data;
  logic         stall;
  logic         hit_ctrl, hit_data, wr_ctrl;

  tacho_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_ce (pulse_ce),
    .tach_in  (tach_in),
    .level    (level),
    .rise     (rise)
  );

  assign hit_ctrl = (bus.csr_a == BASE_ADDR + 5'(TACHO_CTRL));
  assign hit_data = (bus.csr_a == BASE_ADDR + 5'(TACHO_DATA));
  assign wr_ctrl  = bus.csr_we & hit_ctrl;
  // EN as it will be after this clk; lets an EN clear beat a coincident gate.
  assign en_nxt   = wr_ctrl ? bus.csr_di[CTRL_EN] : en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_nxt) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ARM;
        ST_ARM:  if (gate_ce) state_nxt = ST_RUN;
        ST_RUN:  state_nxt = ST_RUN;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en    <= 1'b0;
      cnt   <= 8'd0;
      data  <= 8'd0;
      valid <= 1'b0;
    end else begin
      en <= en_nxt;
      if (!en_nxt) begin
        cnt   <= 8'd0;
        data  <= 8'd0;
        valid <= 1'b0;
      end else begin
        case (state)
          ST_ARM: begin
            if (gate_ce)   cnt <= 8'd0;
            else if (rise) cnt <= sat_inc(cnt);
          end
          ST_RUN: begin
            if (gate_ce) begin
              data  <= cnt;
              valid <= 1'b1;
              cnt   <= rise ? 8'd1 : 8'd0;
            end else if (rise) begin
              cnt <= sat_inc(cnt);
            end
          end
          default: cnt <= 8'd0;
        endcase
      end
    end
  end

`ifdef TACHO_IRQ_EN
  logic [7:0] thresh;
  logic       hit_thresh, stall_set, stall_clr;

  assign hit_thresh = (bus.csr_a == BASE_ADDR + 5'(TACHO_THRESH));
  // cnt here is the value being latched into DATA; THRESH=0 can never trip.
  assign stall_set  = (state == ST_RUN) && gate_ce && en_nxt && (cnt < thresh);
  assign stall_clr  = wr_ctrl & bus.csr_di[CTRL_STALL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= 8'd0;
      stall  <= 1'b0;
    end else begin
      if (bus.csr_we && hit_thresh) thresh <= bus.csr_di;
      stall <= stall_set | (stall & ~stall_clr);
    end
  end

  assign irq = stall & en;
`else
  assign stall = 1'b0;
  assign irq   = 1'b0;
`endif

  always_comb begin
    bus.csr_do = 8'h00;
    if (hit_ctrl) begin
      bus.csr_do[CTRL_EN]    = en;
      bus.csr_do[CTRL_STALL] = stall;
      bus.csr_do[CTRL_VALID] = valid;
    end else if (hit_data) begin
      bus.csr_do = data;
    end
`ifdef TACHO_IRQ_EN
    else if (hit_thresh) begin
      bus.csr_do = thresh;
    end
`endif
  end

endmodule

// File: tb/tb_tacho.sv
// Directed bench for tacho; gate_ce interval scaled to GATE clocks so that a
// 24-clk tach period gives 100 edges per gate. T6 runs when TACHO_IRQ_EN is defined.
module tb_tacho;
  localparam int GATE = 2400;
  localparam logic [4:0] A_CTRL = 5'h1c, A_DATA = 5'h1d, A_THR = 5'h1e;

  logic clk = 1'b0, rst_n = 1'b0;
  logic pulse_ce = 1'b0, gate_ce = 1'b0, tach_in = 1'b0, irq;
  logic pce_all = 1'b0, tach_force = 1'b0;
  int   half = 0, tick = 0;
  int   checks = 0, errors = 0;
  logic [7:0] d;

  tacho_if bus ();

  tacho #(.BASE_ADDR(5'h1c), .FILT_LEN(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_ce (pulse_ce),
    .gate_ce  (gate_ce),
    .tach_in  (tach_in),
    .bus      (bus),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  // pulse_ce every other clk (or every clk) and tach square wave, updated just after negedge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      pulse_ce = pce_all | tick[0];
      tach_in  = (half == 0) ? tach_force : (((tick / half) % 2) == 1);
      tick++;
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] v);
    @(negedge clk);
    bus.csr_a = a; bus.csr_di = v; bus.csr_we = 1'b1;
    @(negedge clk);
    bus.csr_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] v);
    bus.csr_a = a;
    #2;
    v = bus.csr_do;
  endtask

  task automatic gate();
    repeat (GATE - 1) @(negedge clk);
    gate_ce = 1'b1;
    @(negedge clk);
    gate_ce = 1'b0;
  endtask

  initial begin
    bus.csr_a = 5'h0; bus.csr_di = 8'h0; bus.csr_we = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: reset state
    rd(A_CTRL, d); chk("t1_ctrl", d, 8'h00);
    rd(A_DATA, d); chk("t1_data", d, 8'h00);
    rd(A_THR, d);  chk("t1_thresh", d, 8'h00);
    rd(5'h00, d);  chk("t1_other0", d, 8'h00);
    rd(5'h1f, d);  chk("t1_other1f", d, 8'h00);
    chk("t1_irq", {7'd0, irq}, 8'h00);

    // T2: 100 edges per gate, first gate discarded
    half = 12;
    wr(A_CTRL, 8'h01);
    rd(A_CTRL, d); chk("t2_en", d, 8'h01);
    gate();
    rd(A_CTRL, d); chk("t2_ctrl_g1", d, 8'h01);
    rd(A_DATA, d); chk("t2_data_g1", d, 8'h00);
    gate();
    rd(A_CTRL, d); chk("t2_ctrl_g2", d, 8'h81);
    rd(A_DATA, d); chk("t2_data_g2", (d >= 8'd99 && d <= 8'd101) ? 8'd100 : d, 8'd100);
    gate();
    rd(A_DATA, d); chk("t2_data_g3", (d >= 8'd99 && d <= 8'd101) ? 8'd100 : d, 8'd100);

    // T3: 300 edges per gate saturate at ff
    half = 4;
    gate();
    rd(A_DATA, d); chk("t3_sat1", d, 8'hff);
    gate();
    rd(A_DATA, d); chk("t3_sat2", d, 8'hff);
`ifndef TACHO_IRQ_EN
    wr(A_THR, 8'h55);
    rd(A_THR, d); chk("t3_thr_absent", d, 8'h00);
    rd(A_CTRL, d); chk("t3_ctrl", d, 8'h81);
`endif

    // T4: glitch rejection and edge coincident with gate_ce
    pce_all = 1'b1; tach_force = 1'b0; half = 0;
    repeat (10) @(negedge clk);
    gate();
    for (int i = 0; i < 3; i++) begin
      tach_force = 1'b1; @(negedge clk);
      tach_force = 1'b0; repeat (5) @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      tach_force = 1'b1; repeat (6) @(negedge clk);
      tach_force = 1'b0; repeat (6) @(negedge clk);
    end
    gate();
    rd(A_DATA, d); chk("t4_glitch", d, 8'd2);
    repeat (10) @(negedge clk);
    tach_force = 1'b1;
    repeat (4) @(negedge clk);
    gate_ce = 1'b1;
    @(negedge clk);
    gate_ce = 1'b0;
    rd(A_DATA, d); chk("t4_gate_edge_old", d, 8'd0);
    repeat (6) @(negedge clk);
    tach_force = 1'b0;
    gate();
    rd(A_DATA, d); chk("t4_gate_edge_new", d, 8'd1);
    pce_all = 1'b0;

    // T5: EN clear mid-gate, then re-enable
    half = 12;
    repeat (1000) @(negedge clk);
    wr(A_CTRL, 8'h00);
    rd(A_DATA, d); chk("t5_data_clr", d, 8'h00);
    rd(A_CTRL, d); chk("t5_ctrl_clr", d, 8'h00);
    repeat (500) @(negedge clk);
    wr(A_CTRL, 8'h01);
    gate();
    rd(A_CTRL, d); chk("t5_ctrl_g1", d, 8'h01);
    gate();
    rd(A_CTRL, d); chk("t5_ctrl_g2", d, 8'h81);
    rd(A_DATA, d); chk("t5_data_g2", (d >= 8'd99 && d <= 8'd101) ? 8'd100 : d, 8'd100);

    // EN clear coincident with gate_ce: clear wins
    repeat (GATE - 1) @(negedge clk);
    bus.csr_a = A_CTRL; bus.csr_di = 8'h00; bus.csr_we = 1'b1; gate_ce = 1'b1;
    @(negedge clk);
    bus.csr_we = 1'b0; gate_ce = 1'b0;
    rd(A_DATA, d); chk("t5_gate_wr_data", d, 8'h00);
    rd(A_CTRL, d); chk("t5_gate_wr_ctrl", d, 8'h00);

`ifdef TACHO_IRQ_EN
    // T6: stall interrupt with 20 edges per gate
    half = 60;
    wr(A_THR, 8'd50);
    rd(A_THR, d); chk("t6_thresh", d, 8'd50);
    wr(A_CTRL, 8'h01);
    gate();
    chk("t6_irq_arm", {7'd0, irq}, 8'h00);
    gate();
    rd(A_CTRL, d); chk("t6_ctrl_stall", d, 8'hc1);
    chk("t6_irq_set", {7'd0, irq}, 8'h01);
    wr(A_CTRL, 8'h41);
    rd(A_CTRL, d); chk("t6_ctrl_w1c", d, 8'h81);
    chk("t6_irq_clr", {7'd0, irq}, 8'h00);
    gate();
    chk("t6_irq_again", {7'd0, irq}, 8'h01);
    wr(A_THR, 8'd0);
    wr(A_CTRL, 8'h41);
    gate();
    chk("t6_thr0", {7'd0, irq}, 8'h00);
`endif

    // Async reset mid-gate
    half = 12;
    wr(A_CTRL, 8'h01);
    gate(); gate();
    repeat (700) @(negedge clk);
    bus.csr_a = A_DATA;
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_data_now", bus.csr_do, 8'h00);
    rd(A_CTRL, d); chk("rst_ctrl", d, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    rd(A_CTRL, d); chk("rst_ctrl_after", d, 8'h00);
    rd(A_DATA, d); chk("rst_data_after", d, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
